// File: rtl/mini_alu_stack_core.sv
// rtl/mini_alu_stack_core.sv - two-stage MiniAlu sequencer with parametrised
// register file, return-address stack, branch flush and sticky stack errors.
module mini_alu_stack_core #(
   parameter  int ADDR_W      = 16,
   parameter  int DATA_W      = 16,
   parameter  int NUM_REGS    = 8,
   parameter  int STACK_DEPTH = 4,
   parameter  int BTN_W       = 5,
   localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              Clock,
   input  logic              Reset,
   output logic [ADDR_W-1:0] oIP,
   input  logic [27:0]       iInstruction,
   input  logic [BTN_W-1:0]  iBtn,
   output logic              oVGAWe,
   output logic [15:0]       oVGAAddr,
   output logic [2:0]        oVGAColor,
   output logic [7:0]        oLed,
   output logic [SP_W-1:0]   oStackDepth,
   output logic [1:0]        oStackErr
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int STK_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_STO = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
      OP_INC  = 4'h4, OP_BGE = 4'h5, OP_BLE = 4'h6, OP_JMP = 4'h7,
      OP_CALL = 4'h8, OP_RET = 4'h9, OP_VGA = 4'hA, OP_LED = 4'hB,
      OP_BTN  = 4'hC
   } op_e;

   logic [27:0]       dec;
   logic [DATA_W-1:0] regs  [NUM_REGS];
   logic [ADDR_W-1:0] stack [STACK_DEPTH];
   logic [SP_W-1:0]   sp;

   op_e               op;
   logic [7:0]        dst, s1, s0;
   logic [IDX_W-1:0]  dst_i, s1_i, s0_i;
   logic [DATA_W-1:0] rs1, rs0;
   logic [STK_W-1:0]  push_i, top_i;

   logic              taken, push, pop, ovf, unf, wr_en;
   logic [ADDR_W-1:0] target;
   logic [DATA_W-1:0] wr_data;

   assign op     = op_e'(dec[27:24]);
   assign dst    = dec[23:16];
   assign s1     = dec[15:8];
   assign s0     = dec[7:0];
   assign dst_i  = dst[IDX_W-1:0];
   assign s1_i   = s1[IDX_W-1:0];
   assign s0_i   = s0[IDX_W-1:0];
   assign rs1    = regs[s1_i];
   assign rs0    = regs[s0_i];
   assign push_i = STK_W'(sp);
   assign top_i  = STK_W'(sp - SP_W'(1));

   assign oStackDepth = sp;

   always_comb begin
      taken   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      ovf     = 1'b0;
      unf     = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      target  = ADDR_W'(dst);
      case (op)
         OP_STO: begin wr_en = 1'b1; wr_data = DATA_W'({s1, s0}); end
         OP_ADD: begin wr_en = 1'b1; wr_data = rs1 + rs0; end
         OP_SUB: begin wr_en = 1'b1; wr_data = rs1 - rs0; end
         OP_INC: begin wr_en = 1'b1; wr_data = rs1 + DATA_W'(1); end
         OP_BTN: begin wr_en = 1'b1; wr_data = rs1 + DATA_W'(iBtn); end
         OP_BGE: taken = (rs1 >= rs0);
         OP_BLE: taken = (rs1 <= rs0);
         OP_JMP: taken = 1'b1;
         OP_CALL: begin
            if (sp == SP_W'(STACK_DEPTH)) ovf = 1'b1;
            else begin push = 1'b1; taken = 1'b1; end
         end
         OP_RET: begin
            if (sp == '0) unf = 1'b1;
            else begin pop = 1'b1; taken = 1'b1; target = stack[top_i]; end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         oIP       <= '0;
         dec       <= '0;
         sp        <= '0;
         oStackErr <= '0;
         oLed      <= '0;
         oVGAWe    <= 1'b0;
         oVGAAddr  <= '0;
         oVGAColor <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         // A taken transfer replaces the already-fetched next instruction with NOP.
         if (taken) begin
            oIP <= target;
            dec <= '0;
         end else begin
            oIP <= oIP + ADDR_W'(1);
            dec <= iInstruction;
         end
         if (wr_en) regs[dst_i] <= wr_data;
         if (push) sp <= sp + SP_W'(1);
         else if (pop) sp <= sp - SP_W'(1);
         oStackErr <= oStackErr | {ovf, unf};
         if (op == OP_LED) oLed <= rs1[7:0];
         oVGAWe <= (op == OP_VGA);
         if (op == OP_VGA) begin
            oVGAAddr  <= {rs1[7:0], rs0[7:0]};
            oVGAColor <= dst[2:0];
         end
      end
   end

   // While a real instruction sits in decode, oIP already equals its address + 1.
   always_ff @(posedge Clock) begin
      if (!Reset && push) stack[push_i] <= oIP;
   end

endmodule
